// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width, pipeline depth and add/sub opcode encoding.
package alu_pkg;
  localparam int ALU_WIDTH  = 32;
  localparam int ALU_STAGES = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/add_slice.sv
// SW-bit combinational adder slice: the N-bit generalisation of the full-adder cell.
module add_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_cin,
  output logic [SW-1:0] o_sum,
  output logic          o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SW{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one SW-bit slice per stage, carry registered between
// stages, valid/ready handshake on both sides, flags registered alongside the final result.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = ALU_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW  = WIDTH / STAGES;
  localparam int MID = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_badParams
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic [MID-1:0]   r_midValid;
  logic [MID-1:0]   r_midCarry;
  logic [WIDTH-1:0] r_midA   [MID];
  logic [WIDTH-1:0] r_midB   [MID];
  logic [WIDTH-1:0] r_midSum [MID];

  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [STAGES-1:0] w_stValid;
  logic [STAGES-1:0] w_stCin;
  logic [STAGES-1:0] w_sliceCout;
  logic [WIDTH-1:0]  w_stA      [STAGES];
  logic [WIDTH-1:0]  w_stB      [STAGES];
  logic [WIDTH-1:0]  w_stSum    [STAGES];
  logic [WIDTH-1:0]  w_merged   [STAGES];
  logic [SW-1:0]     w_sliceSum [STAGES];
  logic              w_adv;

  // The whole pipe shifts as one unit whenever the output register is free or being drained.
  assign w_adv    = !r_outValid || out_ready;
  assign in_ready = w_adv;

  // Stage 0 takes the raw operands (b pre-inverted for subtract); later stages take the previous register.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_stValid[0] = in_valid;
      assign w_stA[0]     = a;
      assign w_stB[0]     = b ^ {WIDTH{sub}};
      assign w_stSum[0]   = '0;
      assign w_stCin[0]   = sub;
    end else begin : g_next
      assign w_stValid[k] = r_midValid[k-1];
      assign w_stA[k]     = r_midA[k-1];
      assign w_stB[k]     = r_midB[k-1];
      assign w_stSum[k]   = r_midSum[k-1];
      assign w_stCin[k]   = r_midCarry[k-1];
    end

    add_slice #(.SW(SW)) u_slice (
      .i_a    (w_stA[k][k*SW +: SW]),
      .i_b    (w_stB[k][k*SW +: SW]),
      .i_cin  (w_stCin[k]),
      .o_sum  (w_sliceSum[k]),
      .o_cout (w_sliceCout[k])
    );

    assign w_merged[k] = w_stSum[k] | (WIDTH'(w_sliceSum[k]) << (k*SW));
  end

  // Reset clears every valid bit and the visible outputs; data registers hold until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_midValid <= '0;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        r_midValid[i] <= w_stValid[i];
        r_midCarry[i] <= w_sliceCout[i];
        r_midA[i]     <= w_stA[i];
        r_midB[i]     <= w_stB[i];
        r_midSum[i]   <= w_merged[i];
      end
      r_outValid <= w_stValid[STAGES-1];
      r_result   <= w_merged[STAGES-1];
      r_cout     <= w_sliceCout[STAGES-1];
      r_ovf      <= (w_stA[STAGES-1][WIDTH-1] == w_stB[STAGES-1][WIDTH-1]) &&
                    (w_merged[STAGES-1][WIDTH-1] != w_stA[STAGES-1][WIDTH-1]);
      r_zero     <= (w_merged[STAGES-1] == '0);
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: 32-bit/4-stage instance plus an 8-bit/1-stage instance.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, result;

  logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
  logic [7:0] a8, b8, result8;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8), .cout(cout8), .ovf(ovf8),
    .zero(zero8)
  );

  // Hand-computed stream vectors: {a, b, sub} -> {result, cout, ovf, zero}.
  logic [31:0] vecA [8] = '{32'h0000_0010, 32'h7FFF_FFFF, 32'h0000_0000, 32'h1234_5678,
                            32'h0000_FFFF, 32'h8000_0000, 32'h0000_0003, 32'hDEAD_BEEF};
  logic [31:0] vecB [8] = '{32'h0000_0020, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678,
                            32'h0000_0001, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000};
  logic        vecSub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] expR [8] = '{32'h0000_0030, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                            32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF};
  logic        expC [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        expO [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        expZ [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                               input logic isub);
    in_valid = v;
    a        = ia;
    b        = ib;
    sub      = isub;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] r, input logic c,
                             input logic o, input logic z);
    check({tag, " result"}, result, r);
    check({tag, " cout"}, 32'(cout), 32'(c));
    check({tag, " ovf"}, 32'(ovf), 32'(o));
    check({tag, " zero"}, 32'(zero), 32'(z));
  endtask

  // Single op into an empty pipe; measures cycles from presentation to out_valid.
  task automatic runOne(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic [31:0] r, input logic c, input logic o,
                        input logic z);
    int cycles;
    @(negedge clk);
    applyStimulus(1'b1, ia, ib, isub);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'd4);
    checkOutput(tag, r, c, o, z);
    @(negedge clk);
  endtask

  initial begin
    int inIdx, outIdx, cyc;
    logic sawValid;

    rst        = 1'b1;
    out_ready  = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    in_valid8  = 1'b0;
    a8         = '0;
    b8         = '0;
    sub8       = 1'b0;
    out_ready8 = 1'b1;
    repeat (2) @(negedge clk);

    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset8 out_valid", 32'(out_valid8), 32'd0);
    check("reset8 zero", 32'(zero8), 32'd0);
    rst = 1'b0;

    runOne("add 1+2", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    runOne("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runOne("sub ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    runOne("sub 5-7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with out_ready dropped for cycles 5..7.
    inIdx  = 0;
    outIdx = 0;
    cyc    = 0;
    while (outIdx < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (inIdx < 8) applyStimulus(1'b1, vecA[inIdx], vecB[inIdx], vecSub[inIdx]);
      else           applyStimulus(1'b0, '0, '0, 1'b0);
      #1;
      if (cyc >= 5 && cyc <= 7) begin
        check($sformatf("stall%0d out_valid", cyc), 32'(out_valid), 32'd1);
        check($sformatf("stall%0d in_ready", cyc), 32'(in_ready), 32'd0);
        check($sformatf("stall%0d held result", cyc), result, expR[outIdx]);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checkOutput($sformatf("stream op%0d", outIdx), expR[outIdx], expC[outIdx], expO[outIdx],
                    expZ[outIdx]);
        outIdx++;
      end
      if (in_valid && in_ready === 1'b1) inIdx++;
      cyc++;
    end
    check("stream results seen", 32'(outIdx), 32'd8);
    out_ready = 1'b1;

    // Three ops in flight, then a one-cycle reset pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'h100 + 32'(i), 32'h1, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset", 32'h0, 1'b0, 1'b0, 1'b0);
    sawValid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    check("discarded ops stay gone", 32'(sawValid), 32'd0);

    // 8-bit, single-stage instance: one-cycle latency.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0;
    check("w8 7F+01 out_valid", 32'(out_valid8), 32'd1);
    check("w8 7F+01 result", 32'(result8), 32'h80);
    check("w8 7F+01 ovf", 32'(ovf8), 32'd1);
    check("w8 7F+01 cout", 32'(cout8), 32'd0);
    check("w8 7F+01 zero", 32'(zero8), 32'd0);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8 FF+01 result", 32'(result8), 32'h00);
    check("w8 FF+01 cout", 32'(cout8), 32'd1);
    check("w8 FF+01 zero", 32'(zero8), 32'd1);
    check("w8 FF+01 ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    check("w8 drained", 32'(out_valid8), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
